// File: rtl/config_loader_pkg.sv
// config_loader shared definitions: reserved bus addresses, frame size and
// the loader FSM state encoding.
package config_loader_pkg;

    localparam logic [31:0] IDLE_ADDR   = 32'h0000_0000;
    localparam logic [31:0] END_ADDR    = 32'hFFFF_FFFF;
    localparam int          FRAME_BYTES = 8;

    typedef enum logic [1:0] {
        SHIFT,
        APPLY,
        DONE
    } state_t;

endpackage

// File: rtl/config_frame_assembler.sv
// Byte-to-frame assembler: shifts in big-endian bytes and presents the
// completed 64-bit frame combinationally on the cycle its last byte arrives.
module config_frame_assembler
    import config_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        accept,
    output logic [63:0] frame,
    output logic        frame_valid
);

    localparam logic [2:0] LAST = 3'(FRAME_BYTES - 1);

    logic [55:0] shreg;
    logic [2:0]  count;

    // Capture accepted bytes and track position within the frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg <= '0;
            count <= '0;
        end else if (accept) begin
            shreg <= {shreg[47:0], in_data};
            count <= (count == LAST) ? 3'd0 : count + 3'd1;
        end
    end

    // Last byte completes the frame without waiting for a register stage,
    // so the top can drive the bus on the very next cycle.
    always_comb begin
        frame       = {shreg, in_data};
        frame_valid = accept && (count == LAST);
    end

endmodule

// File: rtl/config_loader.sv
// config_loader top: frame decode FSM and config bus drive.
// Optional checksum verification enabled by `define CONFIG_LOADER_CHECKSUM_EN.
module config_loader
    import config_loader_pkg::*;
#(
    parameter int APPLY_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] config_addr,
    output logic [31:0] config_data,
    output logic        config_done,
    output logic        config_error,
    output logic [15:0] frame_count
);

    localparam logic [3:0] HOLD_INIT = 4'(APPLY_CYCLES - 1);

    state_t      state;
    logic [3:0]  hold;
    logic        accept;
    logic [63:0] frame;
    logic        frame_valid;
    logic [31:0] frame_addr;
    logic [31:0] frame_data;
    logic        end_now;
    logic        apply_now;

    config_frame_assembler u_asm (
        .clk         (clk),
        .reset       (reset),
        .in_data     (in_data),
        .accept      (accept),
        .frame       (frame),
        .frame_valid (frame_valid)
    );

    // Classify the frame completing this cycle.
    always_comb begin
        accept     = in_valid && in_ready;
        frame_addr = frame[63:32];
        frame_data = frame[31:0];
        end_now    = 1'b0;
        apply_now  = 1'b0;
        if (state == SHIFT && frame_valid) begin
            end_now   = (frame_addr == END_ADDR);
            apply_now = (frame_addr != END_ADDR) &&
                        (frame_addr != IDLE_ADDR);
        end
    end

    // Loader FSM with registered handshake, bus and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= SHIFT;
            hold        <= '0;
            in_ready    <= 1'b1;
            config_addr <= IDLE_ADDR;
            config_data <= '0;
            config_done <= 1'b0;
            frame_count <= '0;
        end else begin
            unique case (state)
                SHIFT: begin
                    if (end_now) begin
                        state       <= DONE;
                        in_ready    <= 1'b0;
                        config_done <= 1'b1;
                    end else if (apply_now) begin
                        state       <= APPLY;
                        in_ready    <= 1'b0;
                        config_addr <= frame_addr;
                        config_data <= frame_data;
                        hold        <= HOLD_INIT;
                        if (frame_count != 16'hFFFF)
                            frame_count <= frame_count + 16'd1;
                    end
                end
                APPLY: begin
                    if (hold == 4'd0) begin
                        state       <= SHIFT;
                        in_ready    <= 1'b1;
                        config_addr <= IDLE_ADDR;
                        config_data <= '0;
                    end else begin
                        hold <= hold - 4'd1;
                    end
                end
                DONE: begin
                    in_ready <= 1'b0;
                end
                default: begin
                    state    <= SHIFT;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef CONFIG_LOADER_CHECKSUM_EN
    logic [31:0] sum;

    // Running sum of applied frames; end-marker data must match it.
    always_ff @(posedge clk) begin
        if (reset) begin
            sum          <= '0;
            config_error <= 1'b0;
        end else begin
            if (apply_now)
                sum <= sum + frame_addr + frame_data;
            if (end_now)
                config_error <= (frame_data != sum);
        end
    end
`else
    assign config_error = 1'b0;
`endif

endmodule

// File: tb/tb_config_loader.sv
// Randomized scoreboard bench for config_loader.
// Reference model tracks applied frames, frame count and checksum.
module tb_config_loader;

    localparam int AC = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] config_addr;
    logic [31:0] config_data;
    logic        config_done;
    logic        config_error;
    logic [15:0] frame_count;

    int          tests = 0;
    int          fails = 0;
    int          gap_mode = 0;
    logic [63:0] exp_q[$];
    int unsigned exp_count;
    logic [31:0] exp_sum;

    config_loader #(.APPLY_CYCLES(AC)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .config_addr  (config_addr),
        .config_data  (config_data),
        .config_done  (config_done),
        .config_error (config_error),
        .frame_count  (frame_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name,
                         input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every non-idle bus cycle must match the next expected entry.
    always @(negedge clk) begin
        if (!reset && (config_addr != 32'h0 || config_data != 32'h0)) begin
            if (exp_q.size() == 0)
                check("unexpected_bus", {config_addr, config_data}, 64'h0);
            else
                check("bus_frame", {config_addr, config_data},
                      exp_q.pop_front());
            check("ready_low_in_apply", 64'(in_ready), 64'h0);
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int guard = 0;
        if (gap_mode == 2 || (gap_mode == 1 && $urandom_range(0, 2) == 0)) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout: got in_ready 0 expected 1");
        end
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [31:0] a, input logic [31:0] d);
        logic [63:0] f;
        bit          applied;
        int          stall;
        f       = {a, d};
        applied = (a != 32'h0) && (a != 32'hFFFF_FFFF);
        if (applied) begin
            repeat (AC) exp_q.push_back(f);
            if (exp_count < 65535) exp_count++;
            exp_sum = exp_sum + a + d;
        end
        for (int i = 0; i < 8; i++) send_byte(f[63-8*i -: 8]);
        in_valid = 1'b0;
        if (applied) begin
            check("latency_addr", 64'(config_addr), 64'(a));
            stall = 0;
            while (!in_ready && stall < 50) begin
                @(negedge clk);
                stall++;
            end
            check("ready_gap", 64'(stall), 64'(AC));
        end else if (a == 32'h0) begin
            check("drop_ready", 64'(in_ready), 64'h1);
        end
    endtask

    task automatic drain();
        repeat (AC + 3) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'h0);
        check("frame_count", 64'(frame_count), 64'(exp_count));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        exp_count = 0;
        exp_sum   = 32'h0;
        check("rst_ready", 64'(in_ready), 64'h1);
        check("rst_bus", {config_addr, config_data}, 64'h0);
        check("rst_done", 64'(config_done), 64'h0);
        check("rst_error", 64'(config_error), 64'h0);
        check("rst_count", 64'(frame_count), 64'h0);
    endtask

    task automatic send_end(input logic [31:0] d);
        logic exp_err;
        int   taken;
`ifdef CONFIG_LOADER_CHECKSUM_EN
        exp_err = (d != exp_sum);
`else
        exp_err = 1'b0;
`endif
        send_frame(32'hFFFF_FFFF, d);
        check("end_done", 64'(config_done), 64'h1);
        check("end_error", 64'(config_error), 64'(exp_err));
        check("end_ready", 64'(in_ready), 64'h0);
        taken = 0;
        in_valid = 1'b1;
        in_data  = 8'hA5;
        repeat (10) begin
            if (in_ready) taken++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("done_no_consume", 64'(taken), 64'h0);
        check("done_sticky", 64'(config_done), 64'h1);
        check("done_count", 64'(frame_count), 64'(exp_count));
        check("done_bus_idle", {config_addr, config_data}, 64'h0);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        exp_count = 0;
        exp_sum   = 32'h0;
        do_reset();

        gap_mode = 0;
        send_frame(32'h0010_0003, 32'h0000_0005);
        drain();

        gap_mode = 2;
        send_frame(32'h0010_0003, 32'h0000_0005);
        drain();

        gap_mode = 0;
        send_frame(32'h0000_0000, 32'hDEAD_BEEF);
        send_frame(32'h0002_0001, 32'h1234_5678);
        drain();

        send_frame(32'h0003_0004, 32'hCAFE_0001);
        send_frame(32'h0003_0005, 32'hCAFE_0002);
        drain();

        gap_mode = 1;
        for (int i = 0; i < 20; i++) begin
            a = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
            if (a == 32'hFFFF_FFFF) a = 32'h0001_0001;
            d = $urandom | 32'h1;
            send_frame(a, d);
        end
        drain();

        gap_mode = 0;
        for (int i = 0; i < 6; i++) send_byte(8'h11 + 8'(i));
        in_valid = 1'b0;
        do_reset();
        repeat (3) @(negedge clk);
        check("midreset_count", 64'(frame_count), 64'h0);
        send_frame(32'h0004_0002, 32'h0000_00AA);
        drain();

        send_frame(32'h0005_0001, $urandom);
        send_frame(32'h0005_0002, $urandom);
        drain();
        send_end(exp_sum);

        do_reset();
        gap_mode = 1;
        send_frame(32'h0006_0001, $urandom);
        send_frame(32'h0006_0002, $urandom);
        drain();
        send_end(exp_sum ^ 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
